// File: rtl/gain_ramp_mc_if.sv
// Sample stream bundle for gain_ramp_mc: input stream (s_*) and output stream (m_*).
// The slave modport is the gain stage's view, master is the producer/consumer's view.
interface gain_ramp_mc_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned CW     = 1
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DWIDTH-1:0] s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DWIDTH-1:0] m_data;
  logic [CW-1:0]            m_chan;
  logic                     m_clip;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_chan, m_clip
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_chan, m_clip
  );
endinterface

// File: rtl/gain_ramp_mc.sv
// Multichannel TDM gain stage: one shared Q-format gain, ramped per frame,
// round-half-up rescale with saturation, per-sample bypass, 2-stage globally stalled pipe.
module gain_ramp_mc #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned GWIDTH    = 16,
  parameter int unsigned FBITS     = 12,
  parameter int unsigned NCH       = 2,
  parameter int unsigned RAMP_STEP = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [GWIDTH-1:0] gain_tgt,
  input  logic                     gain_ld,
  gain_ramp_mc_if.slave            bus,
  output logic                     ramp_busy
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW = DWIDTH + GWIDTH;

  localparam logic signed [GWIDTH-1:0] UNITY  = GWIDTH'(1 << FBITS);
  localparam logic signed [GWIDTH-1:0] STEP_G = GWIDTH'(RAMP_STEP);
  localparam logic signed [GWIDTH:0]   STEP_D = (GWIDTH+1)'(RAMP_STEP);
  localparam logic signed [PW:0]       RND    = (PW+1)'(1 << (FBITS-1));
  localparam logic signed [DWIDTH-1:0] DMAX   = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic signed [DWIDTH-1:0] DMIN   = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic signed [PW:0]       MAXV   = (PW+1)'(DMAX);
  localparam logic signed [PW:0]       MINV   = (PW+1)'(DMIN);

  logic                     w_adv;
  logic                     w_acc;
  logic                     w_bound;
  logic [CW-1:0]            r_chan;

  logic signed [GWIDTH-1:0] r_cur;
  logic signed [GWIDTH-1:0] r_tgt;
  logic signed [GWIDTH-1:0] w_cur_nxt;
  logic signed [GWIDTH-1:0] w_tgt_nxt;
  logic signed [GWIDTH:0]   w_d;
  logic                     r_busy;

  logic                     r_s1_valid;
  logic                     r_s1_en;
  logic [CW-1:0]            r_s1_chan;
  logic signed [DWIDTH-1:0] r_s1_raw;
  logic signed [PW-1:0]     r_s1_prod;
  logic signed [PW-1:0]     w_prod;

  logic signed [PW:0]       w_sum;
  logic signed [PW:0]       w_r;
  logic signed [DWIDTH-1:0] w_res;
  logic                     w_clip;

  // Whole pipe advances together; a held output stalls everything behind it.
  assign w_adv       = !bus.m_valid || bus.m_ready;
  assign bus.s_ready = w_adv;
  assign w_acc       = bus.s_valid && w_adv;
  assign w_bound     = w_acc && (r_chan == CW'(NCH-1));
  assign ramp_busy   = r_busy;

  // Operands are sign-extended to the full product width, so the product is exact.
  assign w_prod = PW'(bus.s_data) * PW'(r_cur);

  // Ramp step at frame boundary; the difference is taken one bit wider so it cannot wrap.
  always_comb begin
    w_d       = {r_tgt[GWIDTH-1], r_tgt} - {r_cur[GWIDTH-1], r_cur};
    w_cur_nxt = r_cur;
    w_tgt_nxt = gain_ld ? gain_tgt : r_tgt;
    if (w_bound) begin
      if (RAMP_STEP == 0 || (w_d <= STEP_D && w_d >= -STEP_D)) begin
        w_cur_nxt = r_tgt;
      end else if (w_d[GWIDTH]) begin
        w_cur_nxt = r_cur - STEP_G;
      end else begin
        w_cur_nxt = r_cur + STEP_G;
      end
    end
  end

  // Round half up, rescale and saturate; one extra bit keeps the rounding add safe.
  always_comb begin
    w_sum  = {r_s1_prod[PW-1], r_s1_prod} + RND;
    w_r    = w_sum >>> FBITS;
    w_res  = w_r[DWIDTH-1:0];
    w_clip = 1'b0;
    if (w_r > MAXV) begin
      w_res  = DMAX;
      w_clip = 1'b1;
    end else if (w_r < MINV) begin
      w_res  = DMIN;
      w_clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chan      <= '0;
      r_cur       <= UNITY;
      r_tgt       <= UNITY;
      r_busy      <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_en     <= 1'b0;
      r_s1_chan   <= '0;
      r_s1_raw    <= '0;
      r_s1_prod   <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_chan  <= '0;
      bus.m_clip  <= 1'b0;
    end else begin
      r_cur  <= w_cur_nxt;
      r_tgt  <= w_tgt_nxt;
      r_busy <= (w_cur_nxt != w_tgt_nxt);
      if (w_acc) begin
        r_chan <= (r_chan == CW'(NCH-1)) ? '0 : r_chan + CW'(1);
      end
      if (w_adv) begin
        r_s1_valid  <= bus.s_valid;
        bus.m_valid <= r_s1_valid;
        if (w_acc) begin
          r_s1_prod <= w_prod;
          r_s1_raw  <= bus.s_data;
          r_s1_en   <= en;
          r_s1_chan <= r_chan;
        end
        if (r_s1_valid) begin
          bus.m_data <= r_s1_en ? w_res : r_s1_raw;
          bus.m_chan <= r_s1_chan;
          bus.m_clip <= r_s1_en && w_clip;
        end
      end
    end
  end

endmodule

// File: tb/tb_gain_ramp_mc.sv
// Bench for gain_ramp_mc: arithmetic/ramp model compared on every output transfer,
// plus directed literal checks for unity, rounding, saturation, ramp, stall and reset.
module tb_gain_ramp_mc;
  localparam int DW   = 16;
  localparam int GW   = 16;
  localparam int FB   = 12;
  localparam int NCH  = 2;
  localparam int STEP = 256;

  typedef struct {
    int d;
    int ch;
    bit c;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 gain_ld;
  logic signed [GW-1:0] gain_tgt;
  logic                 ramp_busy;

  gain_ramp_mc_if #(.DWIDTH(DW), .CW(1)) bus ();

  gain_ramp_mc #(
    .DWIDTH(DW), .GWIDTH(GW), .FBITS(FB), .NCH(NCH), .RAMP_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .gain_tgt(gain_tgt), .gain_ld(gain_ld),
    .bus(bus), .ramp_busy(ramp_busy)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   md_cur = 4096;
  int   md_tgt = 4096;
  int   md_cnt = 0;
  exp_t expq[$];
  int   log_d[$];
  int   log_c[$];
  bit   log_k[$];
  bit   prev_stall = 0;
  int   prev_d, prev_c;
  bit   prev_k;
  exp_t e;
  int   base;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic exp_t model_out(input int s, input int g, input bit en_s, input int ch);
    exp_t   r;
    longint p, q;
    r.ch = ch;
    r.c  = 0;
    r.d  = s;
    if (en_s) begin
      p = longint'(s) * longint'(g);
      q = (p + (longint'(1) <<< (FB-1))) >>> FB;
      if (q > 32767) begin
        r.d = 32767;  r.c = 1;
      end else if (q < -32768) begin
        r.d = -32768; r.c = 1;
      end else begin
        r.d = int'(q);
      end
    end
    return r;
  endfunction

  // Model and comparison, sampled mid-cycle; events seen here take effect at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      md_cur = 4096;
      md_tgt = 4096;
      md_cnt = 0;
      expq.delete();
      prev_stall = 0;
    end else begin
      chk("ramp_busy", ramp_busy, md_cur != md_tgt);
      if (prev_stall) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", bus.m_data, prev_d);
        chk("hold_chan", bus.m_chan, prev_c);
        chk("hold_clip", bus.m_clip, prev_k);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got data %0d with nothing pending", bus.m_data);
        end else begin
          e = expq.pop_front();
          chk("out_data", bus.m_data, e.d);
          chk("out_chan", bus.m_chan, e.ch);
          chk("out_clip", bus.m_clip, e.c);
          log_d.push_back(int'(bus.m_data));
          log_c.push_back(int'(bus.m_chan));
          log_k.push_back(bus.m_clip);
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_d     = int'(bus.m_data);
      prev_c     = int'(bus.m_chan);
      prev_k     = bus.m_clip;
      if (bus.s_valid && bus.s_ready) begin
        expq.push_back(model_out(int'(bus.s_data), md_cur, en, md_cnt));
        if (md_cnt == NCH-1) begin
          if (md_tgt - md_cur > STEP)       md_cur = md_cur + STEP;
          else if (md_tgt - md_cur < -STEP) md_cur = md_cur - STEP;
          else                              md_cur = md_tgt;
        end
        md_cnt = (md_cnt + 1) % NCH;
      end
      if (gain_ld) md_tgt = int'(gain_tgt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [DW-1:0] d, input logic e_in);
    int w = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    en          = e_in;
    @(negedge clk);
    while (!bus.s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("send_timeout", w, 0);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic load(input logic signed [GW-1:0] g);
    gain_ld  = 1'b1;
    gain_tgt = g;
    tick();
    gain_ld  = 1'b0;
  endtask

  task automatic drain();
    bus.s_valid  = 1'b0;
    bus.m_ready  = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; gain_ld = 1'b0; gain_tgt = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    tick(); tick();
    chk("reset_valid", bus.m_valid, 0);
    chk("reset_data", bus.m_data, 0);
    chk("reset_chan", bus.m_chan, 0);
    chk("reset_clip", bus.m_clip, 0);
    chk("reset_busy", ramp_busy, 0);
    rst = 1'b0;

    // Unity gain, continuous stream: sample i appears two clocks after being presented.
    for (int i = 0; i < 8; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = (i % 2 == 0) ? 16'sd1000 : -16'sd1000;
      tick();
      if (i == 0) begin
        chk("lat_first_valid", bus.m_valid, 0);
      end else begin
        chk("unity_valid", bus.m_valid, 1);
        chk("unity_data", bus.m_data, (i % 2 == 1) ? 1000 : -1000);
        chk("unity_chan", bus.m_chan, (i - 1) % 2);
        chk("unity_clip", bus.m_clip, 0);
      end
    end
    drain();

    // Rounding at gain 0.5 after ramping down 4096 -> 2048 over 8 frames.
    load(16'sd2048);
    repeat (16) send(16'sd0, 1'b1);
    drain();
    chk("round_busy_settled", ramp_busy, 0);
    base = log_d.size();
    send(16'sd3, 1'b1); send(-16'sd3, 1'b1); send(16'sd1, 1'b1); send(-16'sd1, 1'b1);
    drain();
    chk("round_count", log_d.size() - base, 4);
    chk("round_p3", log_d[base], 2);
    chk("round_m3", log_d[base+1], -1);
    chk("round_p1", log_d[base+2], 1);
    chk("round_m1", log_d[base+3], 0);

    // Saturation at the largest positive gain, plus bypass of an overflowing sample.
    load(16'sh7FFF);
    repeat (2 * 121) send(16'sd0, 1'b1);
    drain();
    chk("sat_busy_settled", ramp_busy, 0);
    base = log_d.size();
    send(16'sd20000, 1'b1); send(-16'sd20000, 1'b1); send(16'sd20000, 1'b0);
    drain();
    chk("sat_pos_data", log_d[base], 32767);
    chk("sat_pos_clip", log_k[base], 1);
    chk("sat_neg_data", log_d[base+1], -32768);
    chk("sat_neg_clip", log_k[base+1], 1);
    chk("bypass_data", log_d[base+2], 20000);
    chk("bypass_clip", log_k[base+2], 0);

    // Most negative gain: MIN*MIN saturates high, ordinary sample inverts polarity.
    load(-16'sd32768);
    repeat (2 * 257) send(16'sd0, 1'b1);
    drain();
    base = log_d.size();
    send(-16'sd32768, 1'b1); send(16'sd1000, 1'b1);
    drain();
    chk("minmin_data", log_d[base], 32767);
    chk("minmin_clip", log_k[base], 1);
    chk("neg_gain_data", log_d[base+1], -8000);
    chk("neg_gain_clip", log_k[base+1], 0);

    // Reset mid-ramp with the pipe full.
    load(16'sd0);
    repeat (3) send(16'sd500, 1'b1);
    chk("pre_reset_busy", ramp_busy, 1);
    bus.s_valid = 1'b1; bus.s_data = 16'sd500; rst = 1'b1;
    tick();
    rst = 1'b0; bus.s_valid = 1'b0;
    chk("rst_mid_valid", bus.m_valid, 0);
    chk("rst_mid_busy", ramp_busy, 0);
    base = log_d.size();
    send(16'sd100, 1'b1);
    drain();
    chk("rst_new_count", log_d.size() - base, 1);
    chk("rst_new_data", log_d[base], 100);
    chk("rst_new_chan", log_c[base], 0);

    // Ramp 4096 -> 0 at 256 per frame; realign to a frame start first.
    send(16'sd0, 1'b1);
    drain();
    load(16'sd0);
    base = log_d.size();
    for (int k = 0; k < 18; k++) begin
      send(16'sd4096, 1'b1);
      send(16'sd4096, 1'b1);
      chk("ramp_busy_frame", ramp_busy, k < 15);
    end
    drain();
    for (int k = 0; k < 18; k++) begin
      chk("ramp_frame_ch0", log_d[base+2*k], 4096 - 256 * ((k < 16) ? k : 16));
      chk("ramp_frame_ch1", log_d[base+2*k+1], 4096 - 256 * ((k < 16) ? k : 16));
    end

    // Backpressure: random downstream ready including a 5-clock stall.
    load(16'sd4096);
    base = log_d.size();
    fork
      begin
        for (int i = 0; i < 40; i++) send(16'(i * 37 - 700), (i % 3) != 0);
      end
      begin
        for (int c = 0; c < 120; c++) begin
          bus.m_ready = (c >= 20 && c < 25) ? 1'b0 : 1'($urandom_range(0, 1));
          tick();
        end
        bus.m_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", log_d.size() - base, 40);
    chk("bp_first_bypass", log_d[base], -700);
    chk("bp_fourth_bypass", log_d[base+3], -589);
    chk("bp_chan_order", log_c[base+1], 1);

    chk("pending_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
